bus_arbiter: RTL and testbench

- Two-master to one-slave arbiter between the CPU's instruction-fetch port (read-only) and data port (read/write), and the single Avalon-style bus memory (address/read/write/byteenable/writedata/readdata/waitrequest).
- Registers one grant at a time, holds it until the granted transaction completes, and breaks ties round-robin.
- Includes a watchdog that flags a slave that never drops waitrequest.
- Sits between the CPU top level and the bus memory in the testbench/SoC wrapper.

---
 rtl/bus_arbiter_pkg.sv | 17 +
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and constants for the fetch/data bus arbiter
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } state_t;

    typedef enum logic {
        M_I,
        M_D
    } master_t;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter of fetch and data ports onto one Avalon-style memory
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic              i_waitrequest,
    output logic [31:0]       i_readdata,
    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [3:0]        d_byteenable,
    input  logic [31:0]       d_writedata,
    output logic              d_waitrequest,
    output logic [31:0]       d_readdata,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    output logic              timeout_err
);

    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    master_t    last_gnt_q, last_gnt_d;
    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       timeout_err_q, timeout_err_d;

    logic req_i, req_d;
    logic done, abandon;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_gnt_q    <= M_D;
            wd_cnt_q      <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_gnt_q    <= last_gnt_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        done         = 1'b0;
        abandon      = 1'b0;
        m_address    = '0;
        m_read       = 1'b0;
        m_write      = 1'b0;
        m_byteenable = 4'h0;
        m_writedata  = 32'h0;
        case (state_q)
            IDLE: begin
                // On a tie the master that was not served last wins.
                if (req_i && (!req_d || last_gnt_q == M_D)) begin
                    state_d = GNT_I;
                end else if (req_d) begin
                    state_d = GNT_D;
                end
            end
            GNT_I: begin
                m_address    = i_address;
                m_read       = i_read;
                m_byteenable = BE_FULL;
                if (!req_i) begin
                    abandon = 1'b1;
                end else if (!m_waitrequest) begin
                    done       = 1'b1;
                    last_gnt_d = M_I;
                end
            end
            GNT_D: begin
                m_address    = d_address;
                m_read       = d_read & ~d_write;
                m_write      = d_write;
                m_byteenable = d_byteenable;
                m_writedata  = d_writedata;
                if (!req_d) begin
                    abandon = 1'b1;
                end else if (!m_waitrequest) begin
                    done       = 1'b1;
                    last_gnt_d = M_D;
                end
            end
            default: state_d = IDLE;
        endcase
        if (done || abandon) begin
            state_d = IDLE;
        end
    end

    // Watchdog only observes; a stuck slave keeps its grant.
    always_comb begin
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;
        if (state_q == IDLE || done || abandon) begin
            wd_cnt_d = 8'd0;
        end else if (m_waitrequest && wd_cnt_q != 8'hFF) begin
            wd_cnt_d = wd_cnt_q + 8'd1;
        end
        if (state_q != IDLE && m_waitrequest && wd_cnt_q == WD_LIMIT) begin
            timeout_err_d = 1'b1;
        end
    end

    assign i_waitrequest = (state_q == GNT_I) ? m_waitrequest : req_i;
    assign d_waitrequest = (state_q == GNT_D) ? m_waitrequest : req_d;
    assign i_readdata    = m_readdata;
    assign d_readdata    = m_readdata;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter with a behavioural memory
module tb_bus_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_address = 32'h0;
    logic        i_read = 1'b0;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic [31:0] d_address = 32'h0;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [3:0]  d_byteenable = 4'h0;
    logic [31:0] d_writedata = 32'h0;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        timeout_err;

    bus_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_byteenable(d_byteenable),
        .d_writedata(d_writedata), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_byteenable(m_byteenable),
        .m_writedata(m_writedata), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Memory: an access stalls for stall_now cycles, then completes with data.
    logic [31:0] mem [0:255];
    bit          mem_ready = 1'b0;
    int          cnt = 0;
    int          ws = 1;
    bit          force_wait = 1'b0;
    bit          rnd_ws = 1'b0;
    int          rand_stall = 0;
    int          stall_now;
    logic        access;

    function automatic logic [31:0] init_word(input int k);
        if (k == 0) return 32'h3C1A_BFC0;
        return {16'h0266, 16'(k * 32'h1111)};
    endfunction

    assign stall_now     = rnd_ws ? rand_stall : ws;
    assign access        = m_read | m_write;
    assign m_waitrequest = force_wait | (access & (cnt < stall_now));
    assign m_readdata    = mem[m_address[9:2]];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
            mem_ready <= 1'b1;
        end else if (access && !m_waitrequest) begin
            if (m_write) begin
                for (int b = 0; b < 4; b++)
                    if (m_byteenable[b]) mem[m_address[9:2]][8*b +: 8] <= m_writedata[8*b +: 8];
            end
            cnt        <= 0;
            rand_stall <= $urandom_range(0, 3);
        end else if (access) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        force_wait = 1'b0; rnd_ws = 1'b0; ws = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Returns the 1-based cycle of completion, or -1 if the bound expires.
    task automatic wait_done(input bit is_d, output int cycles);
        logic w;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            w = is_d ? d_waitrequest : i_waitrequest;
        end while (w && cycles < 64);
        if (w) cycles = -1;
    endtask

    typedef struct {
        logic ir, dr, dw;
        logic iw0, dw0;
        logic mr1, mw1;
        logic [31:0] ma1;
        logic iw1, dw1;
    } vec_t;

    vec_t vt[6];
    logic [31:0] ref_mem [0:255];
    int order[$];

    task automatic drive_i(input int n);
        int cyc;
        for (int k = 0; k < n; k++) begin
            i_address = {22'd0, 8'($urandom_range(8, 15)), 2'b00};
            i_read = 1'b1;
            wait_done(1'b0, cyc);
            chk("rand_i_latency_bound", 32'(cyc >= 1 && cyc <= 12), 32'd1);
            @(posedge clk); #1;
            i_read = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic drive_d(input int n);
        int cyc, op;
        for (int k = 0; k < n; k++) begin
            op = $urandom_range(0, 2);
            d_address    = {22'd0, 8'($urandom_range(8, 15)), 2'b00};
            d_byteenable = 4'($urandom_range(0, 15));
            d_writedata  = $urandom;
            d_read  = (op != 1);
            d_write = (op != 0);
            wait_done(1'b1, cyc);
            chk("rand_d_latency_bound", 32'(cyc >= 1 && cyc <= 12), 32'd1);
            @(posedge clk); #1;
            d_read = 1'b0; d_write = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int cyc;
        bit d_hold_ok;
        bit i_fin, d_fin;
        int expect_next;
        bit ci, cd;

        vt[0] = '{1'b0,1'b0,1'b0, 1'b0,1'b0, 1'b0,1'b0, 32'h000, 1'b0,1'b0};
        vt[1] = '{1'b1,1'b0,1'b0, 1'b1,1'b0, 1'b1,1'b0, 32'h100, 1'b1,1'b0};
        vt[2] = '{1'b0,1'b1,1'b0, 1'b0,1'b1, 1'b1,1'b0, 32'h200, 1'b0,1'b1};
        vt[3] = '{1'b0,1'b0,1'b1, 1'b0,1'b1, 1'b0,1'b1, 32'h200, 1'b0,1'b1};
        vt[4] = '{1'b0,1'b1,1'b1, 1'b0,1'b1, 1'b0,1'b1, 32'h200, 1'b0,1'b1};
        vt[5] = '{1'b1,1'b1,1'b0, 1'b1,1'b1, 1'b1,1'b0, 32'h100, 1'b1,1'b1};

        do_reset();
        @(negedge clk);
        chk("reset_m_read", m_read, 0);
        chk("reset_timeout_err", timeout_err, 0);
        chk("reset_m_address", m_address, 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            force_wait = 1'b1;
            i_address = 32'h100; d_address = 32'h200;
            i_read = vt[v].ir; d_read = vt[v].dr; d_write = vt[v].dw;
            @(negedge clk);
            chk($sformatf("vec%0d_idle_iw", v), i_waitrequest, vt[v].iw0);
            chk($sformatf("vec%0d_idle_dw", v), d_waitrequest, vt[v].dw0);
            chk($sformatf("vec%0d_idle_mrw", v), {m_read, m_write}, 2'b00);
            @(negedge clk);
            chk($sformatf("vec%0d_gnt_m_read", v), m_read, vt[v].mr1);
            chk($sformatf("vec%0d_gnt_m_write", v), m_write, vt[v].mw1);
            chk($sformatf("vec%0d_gnt_m_address", v), m_address, vt[v].ma1);
            chk($sformatf("vec%0d_gnt_iw", v), i_waitrequest, vt[v].iw1);
            chk($sformatf("vec%0d_gnt_dw", v), d_waitrequest, vt[v].dw1);
        end

        // Single fetch, one-wait memory: two stall cycles, data in the third.
        do_reset();
        i_address = 32'hBFC0_0000; i_read = 1'b1;
        @(negedge clk);
        chk("fetch_c0_iw", i_waitrequest, 1);
        chk("fetch_c0_m_read", m_read, 0);
        @(negedge clk);
        chk("fetch_c1_iw", i_waitrequest, 1);
        chk("fetch_c1_m_address", m_address, 32'hBFC0_0000);
        chk("fetch_c1_m_be", m_byteenable, 4'hF);
        @(negedge clk);
        chk("fetch_c2_iw", i_waitrequest, 0);
        chk("fetch_c2_data", i_readdata, 32'h3C1A_BFC0);
        chk("fetch_c2_dw", d_waitrequest, 0);
        tick();
        i_read = 1'b0;

        // Simultaneous persistent requests alternate I, D, I, D.
        do_reset();
        i_address = 32'hBFC0_0000; d_address = 32'h4;
        i_read = 1'b1; d_read = 1'b1;
        order.delete();
        d_hold_ok = 1'b1;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            if (order.size() == 0 && !d_waitrequest) d_hold_ok = 1'b0;
            if (i_read && !i_waitrequest) order.push_back(0);
            if (d_read && !d_waitrequest) order.push_back(1);
        end
        tick();
        i_read = 1'b0; d_read = 1'b0;
        chk("tie_count", order.size(), 4);
        chk("tie_d_held", d_hold_ok, 1);
        for (int k = 0; k < order.size() && k < 4; k++)
            chk($sformatf("tie_order%0d", k), order[k], k % 2);

        // Partial write with three stall cycles, then read back.
        do_reset();
        ws = 3;
        d_address = 32'h4; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011; d_write = 1'b1;
        wait_done(1'b1, cyc);
        chk("write_latency", cyc, 5);
        tick();
        d_write = 1'b0;
        tick();
        d_read = 1'b1;
        wait_done(1'b1, cyc);
        chk("readback_data", d_readdata, 32'h0266_BEEF);
        tick();
        d_read = 1'b0;

        // Read and write together: the write wins.
        do_reset();
        d_address = 32'h8; d_writedata = 32'h1122_3344; d_byteenable = 4'hF;
        d_read = 1'b1; d_write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rw_m_read", m_read, 0);
        chk("rw_m_write", m_write, 1);
        wait_done(1'b1, cyc);
        chk("rw_done", 32'(cyc > 0), 1);
        tick();
        d_read = 1'b0; d_write = 1'b0;
        tick();
        chk("rw_mem", mem[2], 32'h1122_3344);

        // Watchdog on a stuck slave, then reset in the middle of the data grant.
        do_reset();
        i_address = 32'hBFC0_0000; i_read = 1'b1;
        wait_done(1'b0, cyc);
        tick();
        i_read = 1'b0;
        tick();
        force_wait = 1'b1;
        d_address = 32'h4; d_read = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 7)  chk("wd_before", timeout_err, 0);
            if (k == 9)  chk("wd_rise", timeout_err, 1);
            if (k == 12) chk("wd_sticky", timeout_err, 1);
            if (k == 12) chk("wd_grant_held", {m_read, d_waitrequest}, 2'b11);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_m_read_drop", m_read, 0);
        chk("rst_m_write_drop", m_write, 0);
        i_read = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_err_clear", timeout_err, 0);
        @(negedge clk);
        chk("rst_tie_addr", m_address, 32'hBFC0_0000);
        chk("rst_tie_read", m_read, 1);
        tick();
        i_read = 1'b0; d_read = 1'b0;

        // Random traffic against a transaction-level memory and fairness model.
        do_reset();
        rnd_ws = 1'b1;
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
        i_fin = 1'b0; d_fin = 1'b0;
        expect_next = -1;
        fork
            begin drive_i(30); i_fin = 1'b1; end
            begin drive_d(30); d_fin = 1'b1; end
            begin
                while (!(i_fin && d_fin)) begin
                    @(negedge clk);
                    ci = i_read && !i_waitrequest;
                    cd = (d_read || d_write) && !d_waitrequest;
                    if (ci && cd) chk("rand_exclusive", 1, 0);
                    if (ci) begin
                        chk("rand_i_data", i_readdata, ref_mem[i_address[9:2]]);
                        if (expect_next >= 0) chk("rand_rr_order", 0, expect_next);
                        expect_next = (d_read || d_write) ? 1 : -1;
                    end
                    if (cd) begin
                        if (d_write) begin
                            for (int b = 0; b < 4; b++)
                                if (d_byteenable[b]) ref_mem[d_address[9:2]][8*b +: 8] = d_writedata[8*b +: 8];
                        end else begin
                            chk("rand_d_data", d_readdata, ref_mem[d_address[9:2]]);
                        end
                        if (expect_next >= 0) chk("rand_rr_order", 1, expect_next);
                        expect_next = i_read ? 0 : -1;
                    end
                end
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
